// File: rtl/l7_operand_fetch.sv
// Operand fetch stage: owns the 32-entry register file with its write-back port,
// performs bypassed combinational reads and loads the ID/EX pipeline register.
module l7_operand_fetch #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned IMMW  = 20,
    parameter int unsigned PCW   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [XLEN-1:0]            Iin,
    input  logic [$clog2(NREGS)-1:0]   Rs1,
    input  logic [$clog2(NREGS)-1:0]   Rs2,
    input  logic [$clog2(NREGS)-1:0]   RD,
    input  logic [IMMW-1:0]            IMM,
    input  logic [PCW-1:0]             pc_in,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       wb_en,
    input  logic [$clog2(NREGS)-1:0]   wb_addr,
    input  logic [XLEN-1:0]            wb_data,
    output logic                       ex_valid,
    output logic [XLEN-1:0]            ex_instr,
    output logic [$clog2(NREGS)-1:0]   ex_rs1,
    output logic [$clog2(NREGS)-1:0]   ex_rs2,
    output logic [$clog2(NREGS)-1:0]   ex_rd,
    output logic [XLEN-1:0]            ex_rs1_val,
    output logic [XLEN-1:0]            ex_rs2_val,
    output logic [XLEN-1:0]            ex_imm,
    output logic [PCW-1:0]             ex_pc
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] rf [NREGS];
    logic            wb_hit_c;
    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;
    logic [XLEN-1:0] imm_ext_c;

    // A write-back that targets x0 never has any architectural effect.
    assign wb_hit_c = wb_en && (wb_addr != AW'(0));

    // Register file write port; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf[i] <= '0;
            end
        end else if (wb_hit_c) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Bypassed read ports: x0 reads zero, a same-cycle write wins over the array.
    always_comb begin
        rd1_c = rf[Rs1];
        rd2_c = rf[Rs2];
        if (Rs1 == AW'(0)) begin
            rd1_c = '0;
        end else if (wb_hit_c && (wb_addr == Rs1)) begin
            rd1_c = wb_data;
        end
        if (Rs2 == AW'(0)) begin
            rd2_c = '0;
        end else if (wb_hit_c && (wb_addr == Rs2)) begin
            rd2_c = wb_data;
        end
    end

    // Sign-extend the raw immediate to the full data width.
    assign imm_ext_c = {{(XLEN-IMMW){IMM[IMMW-1]}}, IMM};

    // ID/EX register: flush beats stall beats load; stalled operands track write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_instr   <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_instr   <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
        end else if (stall) begin
            if (wb_hit_c && (wb_addr == ex_rs1)) begin
                ex_rs1_val <= wb_data;
            end
            if (wb_hit_c && (wb_addr == ex_rs2)) begin
                ex_rs2_val <= wb_data;
            end
        end else begin
            ex_valid   <= id_valid;
            ex_instr   <= Iin;
            ex_rs1     <= Rs1;
            ex_rs2     <= Rs2;
            ex_rd      <= RD;
            ex_rs1_val <= rd1_c;
            ex_rs2_val <= rd2_c;
            ex_imm     <= imm_ext_c;
            ex_pc      <= pc_in;
        end
    end

endmodule

// File: tb/tb_l7_operand_fetch.sv
// Directed bench for the operand fetch stage with hand-computed expectations.
module tb_l7_operand_fetch;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] Iin;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  RD;
    logic [19:0] IMM;
    logic [6:0]  pc_in;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [6:0]  ex_pc;

    int total;
    int bad;

    l7_operand_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .Iin        (Iin),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .RD         (RD),
        .IMM        (IMM),
        .pc_in      (pc_in),
        .stall      (stall),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_instr   (ex_instr),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_rs1_val (ex_rs1_val),
        .ex_rs2_val (ex_rs2_val),
        .ex_imm     (ex_imm),
        .ex_pc      (ex_pc)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        id_valid = 1'b0;
        Iin      = '0;
        Rs1      = '0;
        Rs2      = '0;
        RD       = '0;
        IMM      = '0;
        pc_in    = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;

        step();
        step();
        check("reset_valid", 32'(ex_valid), 32'h0);
        check("reset_instr", ex_instr, 32'h0);
        rst = 1'b0;

        // Valid load together with a write to x9
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0055;
        id_valid = 1'b1; Iin = 32'h0000_0013; pc_in = 7'd3; IMM = 20'h00005; RD = 5'd2;
        step();
        wb_en = 1'b0;
        check("load_valid", 32'(ex_valid), 32'h1);
        check("load_instr", ex_instr, 32'h0000_0013);
        check("load_pc", 32'(ex_pc), 32'h3);
        check("load_imm", ex_imm, 32'h0000_0005);
        check("load_rd", 32'(ex_rd), 32'h2);

        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        check("async_valid", 32'(ex_valid), 32'h0);
        check("async_instr", ex_instr, 32'h0);
        check("async_pc", 32'(ex_pc), 32'h0);
        check("async_imm", ex_imm, 32'h0);
        check("async_rd", 32'(ex_rd), 32'h0);
        step();
        rst = 1'b0;

        // x9 was cleared by reset
        Rs1 = 5'd9; Rs2 = 5'd0; id_valid = 1'b1; Iin = 32'h1; RD = 5'd0; IMM = '0; pc_in = '0;
        step();
        check("post_reset_x9", ex_rs1_val, 32'h0);
        check("post_reset_valid", 32'(ex_valid), 32'h1);

        // Write then read
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        Rs1 = 5'd0; id_valid = 1'b0;
        step();
        wb_en = 1'b0;
        Rs1 = 5'd5; Rs2 = 5'd0; id_valid = 1'b1;
        step();
        check("wr_rd_rs1", ex_rs1_val, 32'hDEAD_BEEF);
        check("wr_rd_rs2", ex_rs2_val, 32'h0);
        check("wr_rd_valid", 32'(ex_valid), 32'h1);

        // Same-cycle bypass into Rs2
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
        Rs1 = 5'd5; Rs2 = 5'd7;
        step();
        wb_en = 1'b0;
        check("bypass_rs2", ex_rs2_val, 32'h1234_5678);
        check("bypass_rs1", ex_rs1_val, 32'hDEAD_BEEF);
        Rs1 = 5'd7; Rs2 = 5'd7;
        step();
        check("later_x7_rs1", ex_rs1_val, 32'h1234_5678);
        check("later_x7_rs2", ex_rs2_val, 32'h1234_5678);

        // Bypass with Rs1 == Rs2
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE_0001;
        step();
        wb_en = 1'b0;
        check("dup_bypass_rs1", ex_rs1_val, 32'hCAFE_0001);
        check("dup_bypass_rs2", ex_rs2_val, 32'hCAFE_0001);

        // Writes to x0 are discarded, and not bypassed
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        Rs1 = 5'd0; Rs2 = 5'd0;
        step();
        wb_en = 1'b0;
        check("x0_bypass", ex_rs1_val, 32'h0);
        step();
        check("x0_read", ex_rs1_val, 32'h0);

        // Stall refresh of held operands
        Rs1 = 5'd3; Rs2 = 5'd4; Iin = 32'h0000_0033; pc_in = 7'd9; IMM = 20'h00010; id_valid = 1'b1;
        step();
        check("pre_stall_rs1", 32'(ex_rs1), 32'h3);
        check("pre_stall_val", ex_rs1_val, 32'h0);
        stall = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_00A5;
        Rs1 = 5'd8; IMM = 20'h00123; Iin = 32'h0000_0099; pc_in = 7'd1; id_valid = 1'b0;
        step();
        check("stall_rs1_val", ex_rs1_val, 32'h0000_00A5);
        check("stall_instr", ex_instr, 32'h0000_0033);
        check("stall_pc", 32'(ex_pc), 32'h9);
        check("stall_valid", 32'(ex_valid), 32'h1);
        check("stall_rs1", 32'(ex_rs1), 32'h3);
        check("stall_imm", ex_imm, 32'h0000_0010);
        wb_addr = 5'd4; wb_data = 32'h0000_0077;
        step();
        check("stall_rs2_val", ex_rs2_val, 32'h0000_0077);
        check("stall_rs1_keep", ex_rs1_val, 32'h0000_00A5);
        wb_en = 1'b0; stall = 1'b0;
        Rs1 = 5'd3; Rs2 = 5'd4; id_valid = 1'b1;
        step();
        check("after_stall_x3", ex_rs1_val, 32'h0000_00A5);
        check("after_stall_x4", ex_rs2_val, 32'h0000_0077);

        // Negative immediate, then flush overriding stall
        IMM = 20'h80000; Iin = 32'h0000_0055; pc_in = 7'd100;
        step();
        check("imm_neg", ex_imm, 32'hFFF8_0000);
        flush = 1'b1; stall = 1'b1;
        step();
        check("flush_valid", 32'(ex_valid), 32'h0);
        check("flush_imm", ex_imm, 32'h0);
        check("flush_instr", ex_instr, 32'h0);
        check("flush_rs1_val", ex_rs1_val, 32'h0);

        // Load without id_valid still captures fields; positive immediate
        flush = 1'b0; stall = 1'b0;
        id_valid = 1'b0; Iin = 32'h0000_0044; IMM = 20'h7FFFF; pc_in = 7'd127;
        step();
        check("novalid_valid", 32'(ex_valid), 32'h0);
        check("novalid_instr", ex_instr, 32'h0000_0044);
        check("imm_pos", ex_imm, 32'h0007_FFFF);
        check("pc_max", 32'(ex_pc), 32'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
